// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking sensor front end.
//   - frame_state_t : SPI frame engine state encoding
//   - range_class_t : near / mid / far classification of a range sample
//   - FRAME_BITS, SAMPLE_W : SPI frame length and useful sample width
//   - DEF_THRESH_NEAR / DEF_THRESH_FAR : default hysteresis thresholds
//   - classify() : maps a sample onto near / mid / far
// -----------------------------------------------------------------------------
package parking_pkg;

   localparam int FRAME_BITS = 16;
   localparam int SAMPLE_W   = 12;

   localparam logic [SAMPLE_W-1:0] DEF_THRESH_NEAR = 12'h200;
   localparam logic [SAMPLE_W-1:0] DEF_THRESH_FAR  = 12'h300;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE
   } frame_state_t;

   typedef enum logic [1:0] {
      CLS_NEAR,
      CLS_MID,
      CLS_FAR
   } range_class_t;

   // Values sitting exactly on a threshold belong to that threshold's class.
   function automatic range_class_t classify(input logic [SAMPLE_W-1:0] s,
                                             input logic [SAMPLE_W-1:0] near_th,
                                             input logic [SAMPLE_W-1:0] far_th);
      range_class_t c;
      if (s <= near_th)
         c = CLS_NEAR;
      else if (s >= far_th)
         c = CLS_FAR;
      else
         c = CLS_MID;
      return c;
   endfunction

endpackage

// File: rtl/spi_rx_frame.sv
// -----------------------------------------------------------------------------
// spi_rx_frame
// Receive-only SPI master engine (CPOL=1). On start (accepted only when idle)
// it drops ss, waits SCLK_DIV cycles, clocks FRAME_BITS bits MSB first with
// SCLK_DIV-cycle low/high phases, holds ss low with sclk high for SCLK_DIV
// cycles, then raises ss and pulses done for one cycle with the frame on data.
// ss stays low for exactly (2*FRAME_BITS+2)*SCLK_DIV cycles.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : frame request, ignored while busy
//   miso       : serial data from the slave
//   ss, sclk   : chip select (active low) and SPI clock, both registered
//   busy       : engine is not idle
//   done       : one-cycle pulse, data valid and updated in the same cycle
//   data       : last completed frame
// -----------------------------------------------------------------------------
module spi_rx_frame
   import parking_pkg::*;
#(
   parameter int SCLK_DIV = 50
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  miso,
   output logic                  ss,
   output logic                  sclk,
   output logic                  busy,
   output logic                  done,
   output logic [FRAME_BITS-1:0] data
);

   localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
   localparam int               BIT_W    = $clog2(FRAME_BITS);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

   frame_state_t          st;
   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] shift_reg;
   logic                  rise_now;

   // Cycle on which sclk is about to rise: MISO is captured here.
   assign rise_now = (st == ST_SHIFT) && (div_cnt == DIV_LAST) && !sclk;
   assign busy     = (st != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ST_IDLE;
         ss      <= 1'b1;
         sclk    <= 1'b1;
         done    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         data    <= '0;
      end else begin
         done <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (start) begin
                  st      <= ST_SETUP;
                  ss      <= 1'b0;
                  div_cnt <= '0;
               end
            end
            ST_SETUP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  sclk    <= 1'b0;
                  st      <= ST_SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     // last high phase complete; sclk stays high into HOLD
                     st <= ST_HOLD;
                  end else begin
                     sclk    <= 1'b0;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  ss      <= 1'b1;
                  done    <= 1'b1;
                  data    <= shift_reg;
                  st      <= ST_DONE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               st <= ST_IDLE;
            end
            default: begin
               st   <= ST_IDLE;
               ss   <= 1'b1;
               sclk <= 1'b1;
            end
         endcase
      end
   end

   // Shift register carries data only; it is fully rewritten every frame.
   always_ff @(posedge clk) begin
      if (rise_now)
         shift_reg <= {shift_reg[FRAME_BITS-2:0], miso};
   end

endmodule

// File: rtl/parking_sensor_spi.sv
// -----------------------------------------------------------------------------
// parking_sensor_spi
// Polls a 12-bit range ADC over SPI every SAMPLE_CYCLES clocks and produces a
// debounced vehicle-present level with near/far hysteresis.
//
// Ports:
//   clk, rst_n   : 100 MHz clock, asynchronous active-low reset
//   MISO         : ADC serial data
//   SS, SCLK     : SPI chip select (active low) and clock (idle high)
//   MOSI         : constant 0, the ADC needs no command
//   parked       : debounced vehicle-present level
//   sample       : last completed 12-bit reading
//   sample_valid : one-cycle pulse when sample updates
// -----------------------------------------------------------------------------
module parking_sensor_spi
   import parking_pkg::*;
#(
   parameter int                  SCLK_DIV      = 50,
   parameter int                  SAMPLE_CYCLES = 1000000,
   parameter logic [SAMPLE_W-1:0] THRESH_NEAR   = DEF_THRESH_NEAR,
   parameter logic [SAMPLE_W-1:0] THRESH_FAR    = DEF_THRESH_FAR,
   parameter int                  DEBOUNCE_N    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                MISO,
   output logic                SS,
   output logic                SCLK,
   output logic                MOSI,
   output logic                parked,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_valid
);

   localparam int               TMR_W    = $clog2(SAMPLE_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_CYCLES - 1);
   localparam int               DEB_W    = $clog2(DEBOUNCE_N + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_N - 1);

   logic [TMR_W-1:0]      tmr;
   logic                  frame_start;
   logic                  frame_busy;
   logic                  frame_done;
   logic [FRAME_BITS-1:0] frame_data;
   logic                  unused_hi;
   logic [DEB_W-1:0]      deb_cnt;
   range_class_t          cls;
   logic                  qualifies;

   assign MOSI = 1'b0;

   // Sample timer: strobe on the wrap, first one SAMPLE_CYCLES after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmr <= '0;
      else if (tmr == TMR_LAST)
         tmr <= '0;
      else
         tmr <= tmr + 1'b1;
   end

   // A strobe landing while a frame is still in flight is dropped.
   assign frame_start = (tmr == TMR_LAST) && !frame_busy;

   spi_rx_frame #(
      .SCLK_DIV (SCLK_DIV)
   ) u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .start (frame_start),
      .miso  (MISO),
      .ss    (SS),
      .sclk  (SCLK),
      .busy  (frame_busy),
      .done  (frame_done),
      .data  (frame_data)
   );

   // Upper frame bits are ADC padding.
   assign unused_hi    = ^frame_data[FRAME_BITS-1:SAMPLE_W];
   assign sample       = frame_data[SAMPLE_W-1:0];
   assign sample_valid = frame_done;

   // A sample "qualifies" when it argues for leaving the current state:
   // near while not parked, far while parked. Anything else restarts the run.
   always_comb begin
      cls       = classify(sample, THRESH_NEAR, THRESH_FAR);
      qualifies = parked ? (cls == CLS_FAR) : (cls == CLS_NEAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parked  <= 1'b0;
         deb_cnt <= '0;
      end else if (sample_valid) begin
         if (!qualifies) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            parked  <= ~parked;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_parking_sensor_spi.sv
`timescale 1ns/1ps
module tb_parking_sensor_spi;

   localparam int          SCLK_DIV      = 2;
   localparam int          SAMPLE_CYCLES = 100;
   localparam int          DEBOUNCE_N    = 3;
   localparam logic [11:0] NEAR          = 12'h200;
   localparam logic [11:0] FAR           = 12'h300;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        MISO  = 1'b0;
   logic        SS, SCLK, MOSI, parked, sample_valid;
   logic [11:0] sample;

   int checks   = 0;
   int failures = 0;

   parking_sensor_spi #(
      .SCLK_DIV      (SCLK_DIV),
      .SAMPLE_CYCLES (SAMPLE_CYCLES),
      .THRESH_NEAR   (NEAR),
      .THRESH_FAR    (FAR),
      .DEBOUNCE_N    (DEBOUNCE_N)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .MISO         (MISO),
      .SS           (SS),
      .SCLK         (SCLK),
      .MOSI         (MOSI),
      .parked       (parked),
      .sample       (sample),
      .sample_valid (sample_valid)
   );

   always #5 clk = ~clk;

   // Slave ADC: latches the word at SS fall, presents next bit on each SCLK fall.
   logic [15:0] slave_word = 16'h0000;
   logic [15:0] cur_word   = 16'h0000;
   int          bit_idx    = 15;
   int          fall_total = 0;

   always @(negedge SS or negedge SCLK) begin
      if (!SS && SCLK) begin
         cur_word = slave_word;
         bit_idx  = 15;
      end else if (!SS && !SCLK) begin
         fall_total++;
         if (bit_idx >= 0) begin
            MISO    = cur_word[bit_idx];
            bit_idx = bit_idx - 1;
         end
      end
   end

   int mosi_bad = 0;
   always @(negedge clk) if (MOSI !== 1'b0) mosi_bad++;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference filter: parked toggles once the most recent DEBOUNCE_N samples
   // since the last toggle all argue for leaving the current state.
   bit m_parked = 1'b0;
   bit hist[$];

   task automatic model_reset();
      m_parked = 1'b0;
      hist.delete();
   endtask

   task automatic model_update(input logic [11:0] s);
      bit q;
      bit all_q;
      q = m_parked ? (s >= FAR) : (s <= NEAR);
      hist.push_back(q);
      if (hist.size() > DEBOUNCE_N) void'(hist.pop_front());
      all_q = (hist.size() == DEBOUNCE_N);
      foreach (hist[k]) if (!hist[k]) all_q = 1'b0;
      if (all_q) begin
         m_parked = !m_parked;
         hist.delete();
      end
   endtask

   task automatic do_frame(input logic [15:0] w);
      logic seen;
      seen       = 1'b0;
      slave_word = w;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (sample_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("frame_seen", 32'(seen), 32'd1);
      if (seen) begin
         check("sample", 32'(sample), 32'(w[11:0]));
         check("parked_before_update", 32'(parked), 32'(m_parked));
         model_update(w[11:0]);
         @(posedge clk); #1;
         check("valid_one_cycle", 32'(sample_valid), 32'd0);
         check("parked_model", 32'(parked), 32'(m_parked));
      end
   endtask

   typedef struct {
      logic [15:0] word;
      logic        exp_parked;
   } vec_t;

   vec_t tbl[$];

   initial begin
      int          n;
      int          low;
      int          fb;
      logic        got_hi;
      logic [11:0] lo;
      logic [3:0]  hi;
      int          sel;

      // mid clears; park debounce; hysteresis; counter clearing; boundaries
      tbl.push_back('{16'hA280, 1'b0});
      tbl.push_back('{16'h0150, 1'b0});
      tbl.push_back('{16'h5150, 1'b0});
      tbl.push_back('{16'hF150, 1'b1});
      for (int i = 0; i < 5; i++) tbl.push_back('{16'h02A0, 1'b1});
      tbl.push_back('{16'h0300, 1'b1});
      tbl.push_back('{16'h3300, 1'b1});
      tbl.push_back('{16'hC300, 1'b0});
      tbl.push_back('{16'h0100, 1'b0});
      tbl.push_back('{16'h01FF, 1'b0});
      tbl.push_back('{16'h0250, 1'b0});
      tbl.push_back('{16'h9050, 1'b0});
      tbl.push_back('{16'h0180, 1'b0});
      tbl.push_back('{16'h0120, 1'b1});
      tbl.push_back('{16'h0FFF, 1'b1});
      tbl.push_back('{16'h0301, 1'b1});
      tbl.push_back('{16'h0300, 1'b0});
      tbl.push_back('{16'h0200, 1'b0});
      tbl.push_back('{16'hE200, 1'b0});
      tbl.push_back('{16'h0200, 1'b1});
      tbl.push_back('{16'h02FF, 1'b1});
      tbl.push_back('{16'h82FF, 1'b1});
      tbl.push_back('{16'h02FF, 1'b1});

      model_reset();
      slave_word = 16'hF1A5;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ss", 32'(SS), 32'd1);
      check("rst_sclk", 32'(SCLK), 32'd1);
      check("rst_mosi", 32'(MOSI), 32'd0);
      check("rst_parked", 32'(parked), 32'd0);
      check("rst_sample", 32'(sample), 32'd0);
      check("rst_valid", 32'(sample_valid), 32'd0);

      @(negedge clk) rst_n = 1'b1;

      // Frame timing after reset
      n = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (!SS) begin
            n = i;
            break;
         end
      end
      check("ss_fall_cycle", n, 100);
      fb     = fall_total;
      low    = 1;
      got_hi = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (SS) begin
            got_hi = 1'b1;
            break;
         end
         low++;
      end
      check("ss_returned_high", 32'(got_hi), 32'd1);
      check("ss_low_cycles", low, 68);
      check("sclk_falls", fall_total - fb, 16);
      check("sclk_idle", 32'(SCLK), 32'd1);
      check("first_valid", 32'(sample_valid), 32'd1);
      check("first_sample", 32'(sample), 32'h1A5);
      check("first_parked", 32'(parked), 32'd0);
      model_update(12'h1A5);
      @(posedge clk); #1;
      check("first_valid_drop", 32'(sample_valid), 32'd0);

      // Table-driven filter vectors
      for (int i = 0; i < tbl.size(); i++) begin
         do_frame(tbl[i].word);
         check("tbl_parked", 32'(parked), 32'(tbl[i].exp_parked));
      end

      // Randomised frames against the reference model
      for (int i = 0; i < 24; i++) begin
         sel = int'($urandom_range(0, 3));
         hi  = 4'($urandom_range(0, 15));
         case (sel)
            0, 1: lo = m_parked ? 12'($urandom_range(12'h300, 12'hFFF))
                                : 12'($urandom_range(0, 12'h200));
            2:    lo = 12'($urandom_range(12'h201, 12'h2FF));
            default: lo = 12'($urandom_range(0, 12'hFFF));
         endcase
         do_frame({hi, lo});
      end

      // Reset during the 8th SCLK low phase
      if (!m_parked) repeat (DEBOUNCE_N) do_frame(16'h0100);
      check("pre_reset_parked", 32'(parked), 32'd1);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!SS) begin
            n = 1;
            break;
         end
      end
      check("reset_frame_started", n, 1);
      fb = fall_total;
      n  = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (fall_total - fb == 8) begin
            n = 1;
            break;
         end
      end
      check("reached_8th_fall", n, 1);
      check("in_low_phase", 32'(SCLK), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ss", 32'(SS), 32'd1);
      check("async_rst_sclk", 32'(SCLK), 32'd1);
      check("async_rst_parked", 32'(parked), 32'd0);
      check("async_rst_sample", 32'(sample), 32'd0);
      model_reset();
      slave_word = 16'h7ABC;
      @(negedge clk) rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (!SS) begin
            n = i;
            break;
         end
      end
      check("post_reset_ss_fall", n, 100);
      do_frame(16'h7ABC);

      check("mosi_always_low", mosi_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
